// File: rtl/imm_scan_ctrl.sv
// imm_scan_ctrl: raster-scan sequencer for the image masking datapath.
// Walks the source image in row-major order, feeds each pixel with its
// coordinates to the masking unit, writes each masked result back to the
// result frame RAM and checks that the masking unit echoes coordinates in order.
//
// Handshake: there is no valid/ready flow control. start is a one-cycle
// request honoured only in IDLE; once accepted, one read is issued per cycle
// and the result RAM must accept one write per cycle (wr_en is a pure strobe).
module imm_scan_ctrl #(
    parameter int IMG_ROWS = 320,
    parameter int IMG_COLS = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [8:0]        mask_row_off_in,
    input  logic [7:0]        mask_col_off_in,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [11:0]       img_data,
    output logic [11:0]       imm_pixel,
    output logic [8:0]        imm_row,
    output logic [7:0]        imm_col,
    output logic [8:0]        imm_mask_row_off,
    output logic [7:0]        imm_mask_col_off,
    input  logic [8:0]        imm_row_ret,
    input  logic [7:0]        imm_col_ret,
    input  logic [11:0]       imm_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              seq_err
);

    localparam logic [8:0] LAST_ROW = 9'(IMG_ROWS - 1);
    localparam logic [7:0] LAST_COL = 8'(IMG_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [8:0]        row_q;
    logic [7:0]        col_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        drain_q;
    logic              busy_q;
    logic              done_q;
    logic [8:0]        roff_q;
    logic [7:0]        coff_q;

    // stage 1: aligned with img_data coming back from the ROM
    logic              s1_valid_q;
    logic [8:0]        s1_row_q;
    logic [7:0]        s1_col_q;
    logic [ADDR_W-1:0] s1_addr_q;

    // stage 2: aligned with the masking unit result
    logic              s2_valid_q;
    logic [8:0]        s2_row_q;
    logic [7:0]        s2_col_q;
    logic [ADDR_W-1:0] s2_addr_q;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [11:0]       wr_data_q;
    logic              seq_err_q;

    logic              accept_d;
    logic              last_pix_d;
    logic              ret_mismatch_d;

    // Decode of the conditions shared by the FSM and the checker
    always_comb begin
        accept_d       = (state_q == S_IDLE) && start;
        last_pix_d     = (row_q == LAST_ROW) && (col_q == LAST_COL);
        ret_mismatch_d = (imm_row_ret != s2_row_q) || (imm_col_ret != s2_col_q);
    end

    // Frame sequencer: read counters, drain timer and busy/done flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            roff_q  <= '0;
            coff_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        roff_q  <= mask_row_off_in;
                        coff_q  <= mask_col_off_in;
                        row_q   <= '0;
                        col_q   <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (last_pix_d) begin
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        // linear address tracks the raster walk, no multiply
                        addr_q <= addr_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 2'd2) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Coordinate pipeline: stage 1 meets the ROM data, stage 2 meets the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_row_q   <= '0;
            s2_col_q   <= '0;
            s2_addr_q  <= '0;
        end else begin
            s1_valid_q <= (state_q == S_SCAN);
            if (state_q == S_SCAN) begin
                s1_row_q  <= row_q;
                s1_col_q  <= col_q;
                s1_addr_q <= addr_q;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_row_q  <= s1_row_q;
                s2_col_q  <= s1_col_q;
                s2_addr_q <= s1_addr_q;
            end
        end
    end

    // Result write stage: one registered write per valid stage-2 pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= s2_valid_q;
            if (s2_valid_q) begin
                wr_addr_q <= s2_addr_q;
                wr_data_q <= imm_result;
            end
        end
    end

    // Sticky order check on echoed coordinates, cleared by an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_err_q <= 1'b0;
        end else if (accept_d) begin
            seq_err_q <= 1'b0;
        end else if (s2_valid_q && ret_mismatch_d) begin
            seq_err_q <= 1'b1;
        end
    end

    // Pixel is gated so the masking unit sees zero outside a live stage-1 slot
    assign imm_pixel        = s1_valid_q ? img_data : 12'd0;
    assign img_addr         = addr_q;
    assign imm_row          = s1_row_q;
    assign imm_col          = s1_col_q;
    assign imm_mask_row_off = roff_q;
    assign imm_mask_col_off = coff_q;
    assign wr_en            = wr_en_q;
    assign wr_addr          = wr_addr_q;
    assign wr_data          = wr_data_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign seq_err          = seq_err_q;

endmodule

// File: tb/tb_imm_scan_ctrl.sv
// tb_imm_scan_ctrl: directed bench for the raster-scan sequencer on a 4x5 image.
module tb_imm_scan_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 5;
    localparam int N    = ROWS * COLS;
    localparam int AW   = 17;

    logic          clk;
    logic          rst;
    logic          start;
    logic [8:0]    mask_row_off_in;
    logic [7:0]    mask_col_off_in;
    logic [AW-1:0] img_addr;
    logic [11:0]   img_data;
    logic [11:0]   imm_pixel;
    logic [8:0]    imm_row;
    logic [7:0]    imm_col;
    logic [8:0]    imm_mask_row_off;
    logic [7:0]    imm_mask_col_off;
    logic [8:0]    imm_row_ret;
    logic [7:0]    imm_col_ret;
    logic [11:0]   imm_result;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          busy;
    logic          done;
    logic          seq_err;

    imm_scan_ctrl #(.IMG_ROWS(ROWS), .IMG_COLS(COLS), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mask_row_off_in(mask_row_off_in), .mask_col_off_in(mask_col_off_in),
        .img_addr(img_addr), .img_data(img_data),
        .imm_pixel(imm_pixel), .imm_row(imm_row), .imm_col(imm_col),
        .imm_mask_row_off(imm_mask_row_off), .imm_mask_col_off(imm_mask_col_off),
        .imm_row_ret(imm_row_ret), .imm_col_ret(imm_col_ret), .imm_result(imm_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .seq_err(seq_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- models ----------------
    function automatic logic [11:0] pix(input int a);
        return 12'((a * 157 + 11) & 32'hfff);
    endfunction

    function automatic logic [11:0] mask_fn(input logic [11:0] p, input logic [8:0] r,
                                            input logic [7:0] c, input logic [8:0] ro,
                                            input logic [7:0] co);
        return p ^ {r[1:0], c[2:0], ro[3:0], co[2:0]};
    endfunction

    bit inject;

    // synchronous image ROM
    always @(posedge clk) img_data <= pix(int'(img_addr));

    // masking unit: registers its inputs, optionally corrupts the echo of pixel 7
    always @(posedge clk) begin
        imm_result  <= mask_fn(imm_pixel, imm_row, imm_col, imm_mask_row_off, imm_mask_col_off);
        imm_row_ret <= imm_row;
        imm_col_ret <= (inject && imm_row == 9'd1 && imm_col == 8'd2) ? imm_col + 8'd1 : imm_col;
    end

    // ---------------- checking ----------------
    int n_cmp;
    int n_fail;
    int n_wr;
    int n_done;
    logic [AW+11:0] exp_q[$];
    logic [AW+11:0] e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // write scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (done) n_done++;
            if (wr_en) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    chk("unexpected write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e[AW+11:12]));
                    chk("wr_data", 32'(wr_data), 32'(e[11:0]));
                end
            end
        end
    end

    // per-cycle expectations for one frame, cycle k = after edge k-1 (start at edge 0)
    typedef struct {
        bit            chk_addr;
        logic [AW-1:0] addr;
        bit            chk_rc;
        logic [8:0]    row;
        logic [7:0]    col;
        logic          busy;
        logic          done;
        logic          wr_en;
    } vec_t;

    vec_t vec[1:25];

    task automatic check_zero(input string tag);
        chk({tag, " img_addr"}, 32'(img_addr), 0);
        chk({tag, " imm_pixel"}, 32'(imm_pixel), 0);
        chk({tag, " imm_row"}, 32'(imm_row), 0);
        chk({tag, " imm_col"}, 32'(imm_col), 0);
        chk({tag, " row_off"}, 32'(imm_mask_row_off), 0);
        chk({tag, " col_off"}, 32'(imm_mask_col_off), 0);
        chk({tag, " wr_en"}, 32'(wr_en), 0);
        chk({tag, " wr_addr"}, 32'(wr_addr), 0);
        chk({tag, " wr_data"}, 32'(wr_data), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " seq_err"}, 32'(seq_err), 0);
    endtask

    task automatic push_frame(input logic [8:0] ro, input logic [7:0] co);
        for (int a = 0; a < N; a++)
            exp_q.push_back({AW'(a), mask_fn(pix(a), 9'(a / COLS), 8'(a % COLS), ro, co)});
    endtask

    task automatic run_frame(input logic [8:0] ro, input logic [7:0] co, input bit use_tbl,
                             input bit mid, input bit exp_err);
        vec_t v;
        push_frame(ro, co);
        n_wr = 0;
        n_done = 0;
        @(negedge clk);
        start = 1'b1;
        mask_row_off_in = ro;
        mask_col_off_in = co;
        @(posedge clk);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            start = 1'b0;
            mask_row_off_in = 9'($urandom_range(0, 511));
            mask_col_off_in = 8'($urandom_range(0, 255));
            if (mid && (k == 3 || k == 10)) start = 1'b1;
            if (use_tbl) begin
                v = vec[k];
                if (v.chk_addr) chk($sformatf("img_addr c%0d", k), 32'(img_addr), 32'(v.addr));
                if (v.chk_rc) begin
                    chk($sformatf("imm_row c%0d", k), 32'(imm_row), 32'(v.row));
                    chk($sformatf("imm_col c%0d", k), 32'(imm_col), 32'(v.col));
                    chk($sformatf("imm_pixel c%0d", k), 32'(imm_pixel), 32'(pix(k - 2)));
                end
                chk($sformatf("busy c%0d", k), 32'(busy), 32'(v.busy));
                chk($sformatf("done c%0d", k), 32'(done), 32'(v.done));
                chk($sformatf("wr_en c%0d", k), 32'(wr_en), 32'(v.wr_en));
            end
            if (k <= 24) begin
                chk($sformatf("row_off c%0d", k), 32'(imm_mask_row_off), 32'(ro));
                chk($sformatf("col_off c%0d", k), 32'(imm_mask_col_off), 32'(co));
            end
            chk($sformatf("seq_err c%0d", k), 32'(seq_err), 32'(exp_err && k >= 11));
        end
        chk("write count", 32'(n_wr), 32'(N));
        chk("done count", 32'(n_done), 32'd1);
        chk("queue empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_fail = 0;
        n_wr = 0;
        n_done = 0;
        inject = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        mask_row_off_in = '0;
        mask_col_off_in = '0;

        for (int k = 1; k <= 25; k++) begin
            vec[k].chk_addr = (k <= N);
            vec[k].addr     = AW'(k - 1);
            vec[k].chk_rc   = (k >= 2 && k <= N + 1);
            vec[k].row      = 9'((k - 2) / COLS);
            vec[k].col      = 8'((k - 2) % COLS);
            vec[k].busy     = (k <= N + 3);
            vec[k].done     = (k == N + 4);
            vec[k].wr_en    = (k >= 4 && k <= N + 3);
        end

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // full frame with timing table and data scoreboard, offsets (1,2)
        run_frame(9'd1, 8'd2, 1'b1, 1'b0, 1'b0);

        // mid-frame start pulses must be ignored
        run_frame(9'd5, 8'd9, 1'b0, 1'b1, 1'b0);

        // corrupted echo of pixel 7 raises sticky seq_err
        inject = 1'b1;
        run_frame(9'd3, 8'd4, 1'b0, 1'b0, 1'b1);
        inject = 1'b0;

        // next start clears it
        run_frame(9'd2, 8'd6, 1'b1, 1'b0, 1'b0);

        // reset in cycle 12 of a frame
        push_frame(9'd7, 8'd1);
        @(negedge clk);
        start = 1'b1;
        mask_row_off_in = 9'd7;
        mask_col_off_in = 8'd1;
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("mid rst");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("post rst wr_en %0d", k), 32'(wr_en), 32'd0);
            chk($sformatf("post rst busy %0d", k), 32'(busy), 32'd0);
        end

        // a new frame completes normally
        run_frame(9'd1, 8'd2, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
